// File: rtl/mem_interface_pkg.sv
// Shared types and default constants for the word-addressed memory interface.
// No logic; latency and backpressure are defined by mem_interface.
package mem_interface_pkg;

  localparam int ADDR_W_DEF      = 9;
  localparam int DATA_W_DEF      = 32;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int STATS_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_interface_mem_array.sv
// Single-port synchronous RAM, registered read (read-before-write), no reset.
// Latency 1 cycle on rdata; no backpressure, accepts an access every cycle.
module mem_array #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR memory front end: IDLE->WAIT->DONE around mem_array; MEM_STATS_EN adds rd/wr counters.
// Done at cycle WAIT_CYCLES+2 after acceptance; requests while busy/done are ignored, bad ones strobe err.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [31:0]       mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] mdatain,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef MEM_STATS_EN
  ,
  output logic [STATS_W-1:0] rd_count,
  output logic [STATS_W-1:0] wr_count
`endif
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mdatain_q, mdatain_d;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;
  logic                addr_oor;

  assign addr_oor = |mar_addr[31:ADDR_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    err_d     = 1'b0;
    mdatain_d = mdatain_q;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          if ((read && write) || addr_oor) begin
            err_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
            addr_d  = mar_addr[ADDR_W-1:0];
            wdata_d = mdr_wdata;
            is_wr_d = write;
          end
        end
      end
      WAIT: begin
        // The final WAIT edge both commits a write and registers the read word.
        if (cnt_q == 4'd0) begin
          ram_we  = is_wr_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!is_wr_q) mdatain_d = ram_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      mdatain_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      err_q     <= err_d;
      mdatain_q <= mdatain_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // RAM output is shown directly in DONE so mdatain is valid without an extra cycle.
  assign mdatain = (state_q == DONE && !is_wr_q) ? ram_rdata : mdatain_q;
  assign busy    = (state_q == WAIT);
  assign done    = (state_q == DONE);
  assign err     = err_q;

`ifdef MEM_STATS_EN
  logic [STATS_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [STATS_W-1:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == DONE) begin
      if (is_wr_q) begin
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
      end else begin
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: one instance with two wait states, one with none.
module tb_mem_interface;

  logic        clk;
  logic        clear;
  logic [31:0] addr_a, wd_a, addr_b, wd_b;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] mdatain_a, mdatain_b;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
`ifdef MEM_STATS_EN
  logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif

  int total = 0;
  int bad   = 0;

  mem_interface #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .clear(clear), .mar_addr(addr_a), .mdr_wdata(wd_a),
    .read(rd_a), .write(wr_a), .mdatain(mdatain_a), .busy(busy_a),
    .done(done_a), .err(err_a)
`ifdef MEM_STATS_EN
    , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
  );

  mem_interface #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .clear(clear), .mar_addr(addr_b), .mdr_wdata(wd_b),
    .read(rd_b), .write(wr_b), .mdatain(mdatain_b), .busy(busy_b),
    .done(done_b), .err(err_b)
`ifdef MEM_STATS_EN
    , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic t();
    @(posedge clk);
    #1;
  endtask

  // Issue one access at cycle 0, drop the request, wait (bounded) for done.
  task automatic run_acc(input bit sel, input bit is_wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int exp_lat,
                         input logic [31:0] exp_rd, input string tag);
    int n;
    if (!sel) begin addr_a = addr; wd_a = wd; wr_a = is_wr; rd_a = !is_wr; end
    else      begin addr_b = addr; wd_b = wd; wr_b = is_wr; rd_b = !is_wr; end
    t();
    rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    n = 1;
    while (!(sel ? done_b : done_a) && n < 20) begin
      t();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (!is_wr) chk({tag, "_rd"}, sel ? mdatain_b : mdatain_a, exp_rd);
    t();
  endtask

  initial begin
    clear = 1'b0;
    addr_a = '0; wd_a = '0; rd_a = 1'b0; wr_a = 1'b0;
    addr_b = '0; wd_b = '0; rd_b = 1'b0; wr_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mdatain", mdatain_a, 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
`ifdef MEM_STATS_EN
    chk("rst_rdc", 32'(rdc_a), 32'h0);
    chk("rst_wrc", 32'(wrc_a), 32'h0);
`endif
    clear = 1'b1;
    t();

    // Write 0xDEADBEEF to 0x05 with cycle-by-cycle status
    addr_a = 32'h5; wd_a = 32'hDEADBEEF; wr_a = 1'b1;
    t();
    wr_a = 1'b0; wd_a = 32'h0;
    chk("w_c1_busy", 32'(busy_a), 32'h1);
    chk("w_c1_done", 32'(done_a), 32'h0);
    t();
    chk("w_c2_busy", 32'(busy_a), 32'h1);
    t();
    chk("w_c3_busy", 32'(busy_a), 32'h1);
    chk("w_c3_done", 32'(done_a), 32'h0);
    t();
    chk("w_c4_done", 32'(done_a), 32'h1);
    chk("w_c4_busy", 32'(busy_a), 32'h0);
    t();
    chk("w_c5_done", 32'(done_a), 32'h0);

    run_acc(0, 0, 32'h5, 32'h0, 4, 32'hDEADBEEF, "r05");
    chk("r05_hold", mdatain_a, 32'hDEADBEEF);

    // Both requests together: err, no access
    run_acc(0, 1, 32'h10, 32'hA5A5A5A5, 4, 32'h0, "w10");
    addr_a = 32'h10; wd_a = 32'h5A5A5A5A; rd_a = 1'b1; wr_a = 1'b1;
    t();
    rd_a = 1'b0; wr_a = 1'b0;
    chk("both_err", 32'(err_a), 32'h1);
    chk("both_busy", 32'(busy_a), 32'h0);
    t();
    chk("both_err_off", 32'(err_a), 32'h0);
    chk("both_busy2", 32'(busy_a), 32'h0);
    run_acc(0, 0, 32'h10, 32'h0, 4, 32'hA5A5A5A5, "r10");

    // Out-of-range address
    addr_a = 32'h200; rd_a = 1'b1;
    t();
    rd_a = 1'b0;
    chk("oor_err", 32'(err_a), 32'h1);
    chk("oor_busy", 32'(busy_a), 32'h0);
    chk("oor_mdatain", mdatain_a, 32'hA5A5A5A5);
    t();
    chk("oor_err_off", 32'(err_a), 32'h0);

    // Reset in the middle of a write
    run_acc(0, 1, 32'h7, 32'h11112222, 4, 32'h0, "w07");
    addr_a = 32'h7; wd_a = 32'h12345678; wr_a = 1'b1;
    t();
    wr_a = 1'b0;
    t();
    clear = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy_a), 32'h0);
    chk("mrst_done", 32'(done_a), 32'h0);
    chk("mrst_err", 32'(err_a), 32'h0);
    chk("mrst_mdatain", mdatain_a, 32'h0);
    clear = 1'b1;
    t();
    run_acc(0, 0, 32'h7, 32'h0, 4, 32'h11112222, "r07");

    // Counted traffic after reset: 3 reads, 2 writes, 1 rejected
    run_acc(0, 1, 32'h20, 32'h00000020, 4, 32'h0, "w20");
    run_acc(0, 1, 32'h21, 32'h00000021, 4, 32'h0, "w21");
    run_acc(0, 0, 32'h20, 32'h0, 4, 32'h00000020, "r20");
    run_acc(0, 0, 32'h21, 32'h0, 4, 32'h00000021, "r21");
    rd_a = 1'b1; wr_a = 1'b1;
    t();
    rd_a = 1'b0; wr_a = 1'b0;
    chk("st_err", 32'(err_a), 32'h1);
    t();
`ifdef MEM_STATS_EN
    chk("st_rdc", 32'(rdc_a), 32'd3);
    chk("st_wrc", 32'(wrc_a), 32'd2);
`endif

    // Zero wait states; address changes while busy
    run_acc(1, 1, 32'h3, 32'hCAFEF00D, 2, 32'h0, "bw3");
    run_acc(1, 1, 32'h4, 32'h0BADF00D, 2, 32'h0, "bw4");
    addr_b = 32'h3; rd_b = 1'b1;
    t();
    rd_b = 1'b0;
    chk("b_c1_busy", 32'(busy_b), 32'h1);
    chk("b_c1_done", 32'(done_b), 32'h0);
    addr_b = 32'h4;
    t();
    chk("b_c2_done", 32'(done_b), 32'h1);
    chk("b_c2_rd", mdatain_b, 32'hCAFEF00D);
    t();
    chk("b_c3_done", 32'(done_b), 32'h0);
    chk("b_c3_hold", mdatain_b, 32'hCAFEF00D);
    run_acc(1, 0, 32'h4, 32'h0, 2, 32'h0BADF00D, "br4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
